// File: rtl/cevero_data_mem_responder.sv
// Memory-side responder for the core data req/gnt/rvalid port: word RAM, fixed-latency in-order responses.
// Define CEVERO_MEM_GNT_STALL_EN to withhold grants pseudo-randomly via an 8-bit LFSR.
module cevero_data_mem_responder #(
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W     = 3;
    localparam logic [32:0] MEM_BYTES = 33'(1) << (ADDR_WIDTH + 2);

    // Illegal configurations stop elaboration.
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $fatal(1, "cevero_data_mem_responder: LATENCY must be in 1..4");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_outstanding
        $fatal(1, "cevero_data_mem_responder: MAX_OUTSTANDING must be in 1..4");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
        $fatal(1, "cevero_data_mem_responder: BASE_ADDR must be 4-byte aligned");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_width
        $fatal(1, "cevero_data_mem_responder: ADDR_WIDTH must be in 1..30");
    end

    logic [31:0]               mem_q [NUM_WORDS];

    logic [CNT_W-1:0]          count_q, count_d;
    logic [LATENCY-1:0]        pipe_valid_q, pipe_valid_d;
    logic [LATENCY-1:0]        pipe_err_q, pipe_err_d;
    logic [LATENCY-1:0][31:0]  pipe_rdata_q, pipe_rdata_d;

    logic [31:0]               offset_c;
    logic                      in_range_c;
    logic [ADDR_WIDTH-1:0]     word_idx_c;
    logic [31:0]               rd_word_c;
    logic [31:0]               wr_word_c;
    logic                      wr_en_c;
    logic                      rsp_valid_c;
    logic [CNT_W-1:0]          busy_c;
    logic                      stall_c;
    logic                      gnt_c;
    logic                      accept_c;

`ifdef CEVERO_MEM_GNT_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4; free-running from the reset seed.
    always_comb begin : lfsr_next
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : lfsr_reg
        if (!rst_ni) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_c = (lfsr_q[1:0] == 2'b00);
`else
    assign stall_c = 1'b0;
`endif

    // Byte offset from the window base; wraps below BASE_ADDR so those land out of range too.
    always_comb begin : decode
        offset_c   = data_addr_i - BASE_ADDR;
        in_range_c = ({1'b0, offset_c} < MEM_BYTES);
        word_idx_c = offset_c[ADDR_WIDTH+1:2];
        rd_word_c  = mem_q[word_idx_c];
    end

    // A slot retiring this cycle is free for a new request in the same cycle.
    always_comb begin : grant
        rsp_valid_c = pipe_valid_q[LATENCY-1];
        busy_c      = count_q - CNT_W'(rsp_valid_c);
        gnt_c       = rst_ni & data_req_i & ~stall_c
                    & (busy_c < CNT_W'(MAX_OUTSTANDING));
        accept_c    = gnt_c;
    end

    // Merge enabled byte lanes of the write data into the current word.
    always_comb begin : write_merge
        wr_en_c   = accept_c & data_we_i & in_range_c;
        wr_word_c = rd_word_c;
        for (int unsigned b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
                wr_word_c[8*b +: 8] = data_wdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin : next_state
        pipe_valid_d = '0;
        pipe_err_d   = '0;
        pipe_rdata_d = '0;
        count_d      = count_q;

        pipe_valid_d[0] = accept_c;
        pipe_err_d[0]   = accept_c & ~in_range_c;
        pipe_rdata_d[0] = (accept_c & ~data_we_i & in_range_c) ? rd_word_c : 32'h0;

        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_err_d[i]   = pipe_err_q[i-1];
            pipe_rdata_d[i] = pipe_rdata_q[i-1];
        end

        if (accept_c && !rsp_valid_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept_c && rsp_valid_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : state_regs
        if (!rst_ni) begin
            count_q      <= '0;
            pipe_valid_q <= '0;
            pipe_err_q   <= '0;
            pipe_rdata_q <= '0;
        end else begin
            count_q      <= count_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_err_q   <= pipe_err_d;
            pipe_rdata_q <= pipe_rdata_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk_i) begin : ram_write
        if (wr_en_c) begin
            mem_q[word_idx_c] <= wr_word_c;
        end
    end

    assign data_gnt_o    = gnt_c;
    assign data_rvalid_o = pipe_valid_q[LATENCY-1];
    assign data_err_o    = pipe_err_q[LATENCY-1];
    assign data_rdata_o  = pipe_rdata_q[LATENCY-1];

endmodule

// File: tb/tb_cevero_data_mem_responder.sv
// Randomized self-checking bench for cevero_data_mem_responder (LATENCY=3, MAX_OUTSTANDING=2, non-zero base).
// Honours CEVERO_MEM_GNT_STALL_EN when the same macro is defined for the build.
module tb_cevero_data_mem_responder;

    localparam int unsigned AW   = 10;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] SPAN = 32'h0000_1000;
    localparam int          LAT  = 3;
    localparam int          MAXO = 2;

    logic        clk_i        = 1'b0;
    logic        rst_ni       = 1'b0;
    logic        data_req_i   = 1'b0;
    logic        data_we_i    = 1'b0;
    logic [3:0]  data_be_i    = 4'h0;
    logic [31:0] data_addr_i  = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    always #5 clk_i = ~clk_i;

    cevero_data_mem_responder #(
        .ADDR_WIDTH      (AW),
        .BASE_ADDR       (BASE),
        .LATENCY         (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .data_req_i    (data_req_i),
        .data_gnt_o    (data_gnt_o),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    exp_t        exp_q[$];
    rsp_t        resp_log[$];
    logic [31:0] mem_m [1024];
    int          checks     = 0;
    int          errors     = 0;
    int          cyc        = 0;
    int          stall_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic rsp_t last_rsp(input int back);
        rsp_t r;
        r.cyc   = -1;
        r.err   = 1'bx;
        r.rdata = 32'hxxxx_xxxx;
        if (resp_log.size() > back) r = resp_log[resp_log.size() - 1 - back];
        return r;
    endfunction

    // Reference: every accepted request owes one response exactly LAT cycles later, in order.
    task automatic monitor();
        exp_t        e;
        rsp_t        r;
        logic [31:0] off;
        int          idx;
        logic        exp_rv;
        logic        exp_gnt;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                exp_q.delete();
                chk("rst_gnt", 32'(data_gnt_o), 32'h0);
                chk("rst_rvalid", 32'(data_rvalid_o), 32'h0);
                chk("rst_rdata", data_rdata_o, 32'h0);
                chk("rst_err", 32'(data_err_o), 32'h0);
            end else begin
                exp_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                chk("rvalid", 32'(data_rvalid_o), 32'(exp_rv));
                if (data_rvalid_o) begin
                    r.cyc   = cyc;
                    r.err   = data_err_o;
                    r.rdata = data_rdata_o;
                    resp_log.push_back(r);
                end
                if (exp_rv) begin
                    e = exp_q.pop_front();
                    chk("rdata", data_rdata_o, e.rdata);
                    chk("err", 32'(data_err_o), 32'(e.err));
                end else begin
                    chk("idle_rdata", data_rdata_o, 32'h0);
                    chk("idle_err", 32'(data_err_o), 32'h0);
                end
                exp_gnt = data_req_i && (exp_q.size() < MAXO);
`ifdef CEVERO_MEM_GNT_STALL_EN
                if (data_gnt_o) chk("gnt_legal", 32'(data_gnt_o), 32'(exp_gnt));
                if (exp_gnt && !data_gnt_o) stall_seen++;
`else
                chk("gnt", 32'(data_gnt_o), 32'(exp_gnt));
`endif
                if (data_req_i && data_gnt_o) begin
                    off     = data_addr_i - BASE;
                    e.due   = cyc + LAT;
                    e.err   = (off >= SPAN);
                    e.rdata = 32'h0;
                    if (!e.err) begin
                        idx = int'(off >> 2);
                        if (data_we_i) begin
                            for (int b = 0; b < 4; b++) begin
                                if (data_be_i[b]) mem_m[idx][8*b +: 8] = data_wdata_i[8*b +: 8];
                            end
                        end else begin
                            e.rdata = mem_m[idx];
                        end
                    end
                    exp_q.push_back(e);
                end
            end
            cyc++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Present one request and hold it until granted; reports wait cycles and accept cycle.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output int waits, output int acc);
        logic g;
        waits        = 0;
        acc          = -1;
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = addr;
        data_be_i    = be;
        data_wdata_i = wd;
        forever begin
            @(negedge clk_i);
            g = data_gnt_o;
            @(posedge clk_i);
            #1;
            if (g) begin
                acc = cyc - 1;
                break;
            end
            waits++;
            if (waits > 60) begin
                checks++;
                errors++;
                $display("FAIL req_timeout: no grant after %0d cycles for addr %h", waits, addr);
                break;
            end
        end
        data_req_i   = 1'b0;
        data_we_i    = 1'($urandom);
        data_addr_i  = $urandom;
        data_be_i    = 4'($urandom);
        data_wdata_i = $urandom;
    endtask

    initial begin
        int          w;
        int          a;
        int          n0;
        int          sel;
        int          wv[4];
        logic [31:0] addr;
        rsp_t        r;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_req(1'b1, BASE + 32'(4 * i), 4'hF, 32'hC0DE_0000 + 32'(i), w, a);
        end
        idle(LAT + 3);

        // Full write then read-back with latency measurement.
        do_req(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, w, a);
        do_req(1'b0, BASE + 32'h10, 4'h0, 32'h0, w, a);
`ifndef CEVERO_MEM_GNT_STALL_EN
        chk("t1_gnt_wait", 32'(w), 32'h0);
`endif
        idle(LAT + 3);
        r = last_rsp(0);
        chk("t1_rdata", r.rdata, 32'hDEAD_BEEF);
        chk("t1_err", 32'(r.err), 32'h0);
        chk("t1_latency", 32'(r.cyc - a), 32'(LAT));

        // Byte-enable merge.
        do_req(1'b1, BASE + 32'h20, 4'hF, 32'h1122_3344, w, a);
        do_req(1'b1, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD, w, a);
        do_req(1'b0, BASE + 32'h20, 4'hF, 32'h0, w, a);
        idle(LAT + 3);
        r = last_rsp(0);
        chk("t2_rdata", r.rdata, 32'h11BB_33DD);

        // Out-of-range above and below the window; aliased write must not land.
        do_req(1'b0, BASE + SPAN, 4'hF, 32'h0, w, a);
        idle(LAT + 3);
        r = last_rsp(0);
        chk("t3_oor_err", 32'(r.err), 32'h1);
        chk("t3_oor_rdata", r.rdata, 32'h0);
        do_req(1'b0, BASE - 32'h4, 4'hF, 32'h0, w, a);
        do_req(1'b1, BASE + SPAN, 4'hF, 32'hFFFF_FFFF, w, a);
        do_req(1'b0, BASE, 4'hF, 32'h0, w, a);
        idle(LAT + 3);
        r = last_rsp(2);
        chk("t3_below_err", 32'(r.err), 32'h1);
        r = last_rsp(1);
        chk("t3_oor_wr_err", 32'(r.err), 32'h1);
        r = last_rsp(0);
        chk("t3_alias_rdata", r.rdata, 32'hC0DE_0000);
        do_req(1'b1, BASE, 4'hF, 32'h5A5A_0001, w, a);
        do_req(1'b0, BASE, 4'hF, 32'h0, w, a);
        idle(LAT + 3);
        r = last_rsp(0);
        chk("t3_inrange_rdata", r.rdata, 32'h5A5A_0001);
        chk("t3_inrange_err", 32'(r.err), 32'h0);

        // Four back-to-back reads against the outstanding limit.
        for (int k = 0; k < 4; k++) begin
            do_req(1'b0, BASE + 32'(4 * (10 + k)), 4'hF, 32'h0, wv[k], a);
        end
`ifndef CEVERO_MEM_GNT_STALL_EN
        chk("t4_wait0", 32'(wv[0]), 32'h0);
        chk("t4_wait1", 32'(wv[1]), 32'h0);
        chk("t4_wait2", 32'(wv[2]), 32'h1);
        chk("t4_wait3", 32'(wv[3]), 32'h0);
`endif
        idle(LAT + 3);
        for (int k = 0; k < 4; k++) begin
            r = last_rsp(3 - k);
            chk("t4_order", r.rdata, 32'hC0DE_000A + 32'(k));
        end

        // Reset with two reads in flight.
        n0 = resp_log.size();
        do_req(1'b0, BASE + 32'h4, 4'hF, 32'h0, w, a);
        do_req(1'b0, BASE + 32'h8, 4'hF, 32'h0, w, a);
        rst_ni = 1'b0;
        idle(3);
        rst_ni = 1'b1;
        idle(LAT + 4);
        chk("t5_no_rsp", 32'(resp_log.size() - n0), 32'h0);
        do_req(1'b0, BASE + 32'h10, 4'hF, 32'h0, w, a);
`ifndef CEVERO_MEM_GNT_STALL_EN
        chk("t5_gnt_wait", 32'(w), 32'h0);
`endif
        idle(LAT + 3);
        r = last_rsp(0);
        chk("t5_kept_rdata", r.rdata, 32'hDEAD_BEEF);

        // Random mix of reads, partial writes and out-of-range accesses.
        for (int t = 0; t < 100; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8) begin
                addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            end else if (sel == 8) begin
                addr = BASE + SPAN + 32'(4 * $urandom_range(0, 15));
            end else begin
                addr = BASE - 32'(4 * $urandom_range(1, 16));
            end
            do_req(1'($urandom_range(0, 1)), addr, 4'($urandom), $urandom, w, a);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(LAT + 4);
        chk("drain_pending", 32'(exp_q.size()), 32'h0);
`ifdef CEVERO_MEM_GNT_STALL_EN
        chk("stall_seen", 32'(stall_seen > 0), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
